fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side drain stage for the 8-bit asynchronous FIFO. Lives entirely in the read clock domain and drives the FIFO's `rd_en` from its `empty` flag. Captures each `data_out` byte and packs PACK consecutive bytes into one little-endian word. Presents the words on a valid/ready stream, with a flush input that emits a partial word qualified by a byte-keep mask.

## Interface
- Data_Width, 8, FIFO byte width (bits per lane)
- PACK, 4, bytes per output word; legal range 2..8
- rd_clk  in  1  read-domain clock; all logic on rising edge
- rd_rst  in  1  reset, asynchronous, active-high
- fifo_empty  in  1  FIFO empty flag (rd_clk domain)
- fifo_rd_en  out  1  FIFO read strobe
- fifo_data_out  in  Data_Width  FIFO read data; valid exactly 1 cycle after a sampled read
- flush  in  1  request to emit the current partial word
- m_data  out  Data_Width*PACK  packed word; byte 0 in [Data_Width-1:0]
- m_keep  out  PACK  lane-valid mask; bit i qualifies byte i
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- word_count  out  32  count of accepted output words

## Operation
- Registered state:
  - acc (PACK lanes) and keep_acc
  - cnt: filled lanes, 0..PACK
  - pend: 1 read in flight
  - flush_req: sticky
  - output register: m_data, m_keep, m_valid
- fifo_rd_en = !rd_rst && !fifo_empty && !flush_req && (cnt + pend < PACK).
  - Combinational from registered state plus fifo_empty.
  - Never asserted while empty, so the FIFO is never over-read.
- pend <= fifo_rd_en each cycle.
- When pend=1, fifo_data_out is written into lane cnt, keep_acc[cnt] is set, and cnt increments.
- Word complete: cnt reaches PACK, counting the byte arriving this cycle.
  - Transfers acc→output register when (!m_valid || m_ready).
  - On transfer, m_keep is all ones and cnt/keep_acc clear in the same cycle.
  - If the output register is blocked, acc holds full (cnt=PACK); no reads issue until the transfer.
- Flush:
  - flush=1 sets flush_req; new reads stop immediately.
  - Once pend=0 and cnt>0, acc transfers on the same output condition with m_keep=keep_acc; unfilled lanes of m_data are 0.
  - flush_req clears on that transfer.
  - If cnt=0 and pend=0, flush_req clears with no output.
- State view, derived from cnt, pend and flush_req:
  - FILL: cnt<PACK, no flush.
  - FULL_WAIT: cnt=PACK, output blocked.
  - FLUSH_DRAIN: flush_req=1, pend=1.
  - FLUSH_EMIT: flush_req=1, pend=0, cnt>0.
  - Every state returns to FILL.
- Output register:
  - Holds m_data/m_keep stable while m_valid && !m_ready.
  - m_valid clears on handshake unless a new word loads in the same cycle. Back-to-back words are allowed.
- word_count increments on each m_valid && m_ready and wraps 2^32-1 → 0.

## Timing
- Reset values, with rd_rst asserted asynchronously:
  - fifo_rd_en=0, m_valid=0, m_data=0, m_keep=0, word_count=0
  - cnt=0, pend=0, flush_req=0
- Reset mid-operation: any in-flight byte and partial word are discarded. The byte presented after reset release is ignored because pend=0.
- First rd_en can assert in the first rd_clk cycle after reset release if fifo_empty=0.
- Read-to-capture latency: 1 cycle.
- Last byte arrival to m_valid: 1 cycle, if the output register is free.
- Sustained throughput with m_ready=1 and a non-empty FIFO: PACK bytes per PACK+1 cycles.
- fifo_empty rising in the cycle after a read does not cancel pend; that byte is still captured.
- flush and a completing byte in the same cycle: the full word emits with keep all ones, then flush_req finds cnt=0 and clears.
- m_ready may toggle arbitrarily; there is no combinational path from m_ready to fifo_rd_en.

## Test plan
- Reset: hold rd_rst with fifo_empty=0 -> fifo_rd_en=0, m_valid=0, word_count=0. Release -> fifo_rd_en=1 on the next cycle.
- Streaming: FIFO holds 0x01..0x08, m_ready=1 -> words 0x04030201 then 0x08070605, m_keep=0xF, word_count=2, exactly 8 rd_en pulses.
- Backpressure: m_ready=0 with 8 bytes available -> one word held stable, a second accumulated (cnt=4), rd_en=0. Raise m_ready -> both words delivered in order.
- Flush partial: push 0xAA, 0xBB, then flush with FIFO empty -> m_data=0x0000BBAA, m_keep=0x3. A flush with cnt=0 produces no word.
- Flush racing a read: flush asserted the same cycle rd_en fires for the 3rd byte 0xCC -> the in-flight byte is captured, m_keep=0x7, m_data=0x00CCBBAA.
- Reset mid-word: assert rd_rst after 2 bytes captured and 1 pending -> no output word. Post-reset packing starts at lane 0 and word_count wraps correctly from 0xFFFFFFFF to 0 when preloaded via a long run.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO drain: packs PACK bytes little-endian into a valid/ready word stream, flush emits partial words.
// Capture 1 cycle after rd_en, word valid 1 cycle after last byte; a blocked output register stalls further reads.
module fifo_rd_packer #(
  parameter int Data_Width = 8,
  parameter int PACK       = 4
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  input  logic [Data_Width-1:0]      fifo_data_out,
  input  logic                       flush,
  output logic [Data_Width*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [31:0]                word_count
);

  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  logic [PACK-1:0][Data_Width-1:0] acc, acc_n;
  logic [PACK-1:0]                 keep_acc, keep_n;
  logic [CW-1:0]                   cnt, cnt_n;
  logic                            pend, flush_req;
  logic                            full, emit_part, out_free, load;

  // Reads already in flight count against free lanes so the accumulator never overflows.
  assign fifo_rd_en = !rd_rst && !fifo_empty && !flush_req &&
                      (({1'b0, cnt} + {{CW{1'b0}}, pend}) < {1'b0, PACK_C});

  always_comb begin
    acc_n  = acc;
    keep_n = keep_acc;
    cnt_n  = cnt;
    if (pend) begin
      for (int i = 0; i < PACK; i++) begin
        if (cnt == CW'(i)) begin
          acc_n[i]  = fifo_data_out;
          keep_n[i] = 1'b1;
        end
      end
      cnt_n = cnt + CW'(1);
    end
  end

  assign out_free  = !m_valid || m_ready;
  assign full      = (cnt_n == PACK_C);
  assign emit_part = flush_req && !pend && (cnt != '0);
  assign load      = out_free && (full || emit_part);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      acc        <= '0;
      keep_acc   <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      flush_req  <= 1'b0;
      m_data     <= '0;
      m_keep     <= '0;
      m_valid    <= 1'b0;
      word_count <= '0;
    end else begin
      pend <= fifo_rd_en;
      if (load) begin
        // Unfilled lanes are already zero because acc clears on every transfer.
        m_data   <= acc_n;
        m_keep   <= full ? {PACK{1'b1}} : keep_n;
        m_valid  <= 1'b1;
        acc      <= '0;
        keep_acc <= '0;
        cnt      <= '0;
      end else begin
        acc      <= acc_n;
        keep_acc <= keep_n;
        cnt      <= cnt_n;
        if (m_ready) m_valid <= 1'b0;
      end
      if (flush)
        flush_req <= 1'b1;
      else if (flush_req && !pend && (cnt == '0 || load))
        flush_req <= 1'b0;
      if (m_valid && m_ready) word_count <= word_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a small behavioural FIFO feeding it.
module tb_fifo_rd_packer;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_data_out = 8'h00;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] word_count;

  int checks = 0;
  int passed = 0;

  logic [7:0] mem [256];
  int n_push = 0;
  int n_pop  = 0;

  fifo_rd_packer #(.Data_Width(8), .PACK(4)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data_out(fifo_data_out), .flush(flush), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_ready(m_ready), .word_count(word_count)
  );

  always #5 rd_clk = ~rd_clk;

  assign fifo_empty = (n_push == n_pop);

  // Read data appears the cycle after a sampled read, as the real FIFO does.
  always @(posedge rd_clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= mem[n_pop[7:0]];
      n_pop         <= n_pop + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[n_push[7:0]] = b;
    n_push = n_push + 1;
  endtask

  task automatic wait_word(output logic [31:0] d, output logic [3:0] k, output bit ok);
    ok = 1'b0; d = '0; k = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge rd_clk);
      if (m_valid) begin
        d = m_data; k = m_keep; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge rd_clk);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    rd_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [3:0] k; bit ok;
    rd_rst = 1'b1; flush = 1'b0; m_ready = 1'b1;
    push(8'h11);
    repeat (2) @(negedge rd_clk);
    checks++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else passed++;
    checks++; if (word_count !== 32'd0) $display("FAIL reset_word_count got %h want 0", word_count); else passed++;
    checks++; if (m_data !== 32'd0) $display("FAIL reset_m_data got %h want 0", m_data); else passed++;
    checks++; if (m_keep !== 4'h0) $display("FAIL reset_m_keep got %h want 0", m_keep); else passed++;
    rd_rst = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) $display("FAIL release_rd_en got %b want 1", fifo_rd_en); else passed++;
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    wait_word(d, k, ok);
    checks++; if (!ok) $display("FAIL single_byte_word got no word want one"); else passed++;
    checks++; if (d !== 32'h00000011) $display("FAIL single_byte_data got %h want 00000011", d); else passed++;
    checks++; if (k !== 4'h1) $display("FAIL single_byte_keep got %h want 1", k); else passed++;
    repeat (2) @(negedge rd_clk);
    checks++; if (word_count !== 32'd1) $display("FAIL single_byte_count got %0d want 1", word_count); else passed++;
  endtask

  task automatic test_streaming();
    logic [31:0] d; logic [3:0] k; bit ok; int base;
    do_reset();
    m_ready = 1'b1;
    base = n_pop;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_word(d, k, ok);
    checks++; if (!ok || d !== 32'h04030201) $display("FAIL stream_word0 got %h want 04030201", d); else passed++;
    checks++; if (k !== 4'hF) $display("FAIL stream_keep0 got %h want f", k); else passed++;
    wait_word(d, k, ok);
    checks++; if (!ok || d !== 32'h08070605) $display("FAIL stream_word1 got %h want 08070605", d); else passed++;
    checks++; if (k !== 4'hF) $display("FAIL stream_keep1 got %h want f", k); else passed++;
    repeat (3) @(negedge rd_clk);
    checks++; if (word_count !== 32'd2) $display("FAIL stream_count got %0d want 2", word_count); else passed++;
    checks++; if (n_pop - base !== 8) $display("FAIL stream_rd_pulses got %0d want 8", n_pop - base); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL stream_idle_valid got %b want 0", m_valid); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] d; logic [3:0] k; bit ok; int base;
    do_reset();
    m_ready = 1'b0;
    base = n_pop;
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    repeat (8) @(negedge rd_clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 32'h13121110) $display("FAIL bp_held_early got %b/%h want 1/13121110", m_valid, m_data); else passed++;
    repeat (12) @(negedge rd_clk);
    checks++; if (m_data !== 32'h13121110) $display("FAIL bp_held_late got %h want 13121110", m_data); else passed++;
    checks++; if (m_keep !== 4'hF) $display("FAIL bp_keep got %h want f", m_keep); else passed++;
    checks++; if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en got %b want 0", fifo_rd_en); else passed++;
    checks++; if (n_pop - base !== 8) $display("FAIL bp_bytes_read got %0d want 8", n_pop - base); else passed++;
    m_ready = 1'b1;
    wait_word(d, k, ok);
    checks++; if (!ok || d !== 32'h17161514) $display("FAIL bp_second_word got %h want 17161514", d); else passed++;
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    wait_word(d, k, ok);
    checks++; if (!ok || d !== 32'h00000018) $display("FAIL bp_tail_data got %h want 00000018", d); else passed++;
    checks++; if (k !== 4'h1) $display("FAIL bp_tail_keep got %h want 1", k); else passed++;
    repeat (2) @(negedge rd_clk);
    checks++; if (word_count !== 32'd3) $display("FAIL bp_count got %0d want 3", word_count); else passed++;
  endtask

  task automatic test_flush_partial();
    logic [31:0] d; logic [3:0] k; bit ok; int seen;
    do_reset();
    m_ready = 1'b1;
    push(8'hAA); push(8'hBB);
    repeat (5) @(negedge rd_clk);
    checks++; if (m_valid !== 1'b0) $display("FAIL partial_no_early_word got %b want 0", m_valid); else passed++;
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    wait_word(d, k, ok);
    checks++; if (!ok || d !== 32'h0000BBAA) $display("FAIL partial_data got %h want 0000bbaa", d); else passed++;
    checks++; if (k !== 4'h3) $display("FAIL partial_keep got %h want 3", k); else passed++;
    @(negedge rd_clk);
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge rd_clk);
      if (m_valid) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL empty_flush_words got %0d want 0", seen); else passed++;
    checks++; if (word_count !== 32'd1) $display("FAIL empty_flush_count got %0d want 1", word_count); else passed++;
  endtask

  task automatic test_flush_race();
    logic [31:0] d; logic [3:0] k; bit ok; bit hit;
    do_reset();
    m_ready = 1'b1;
    push(8'hAA); push(8'hBB); push(8'hCC);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      if (fifo_rd_en && !fifo_empty && mem[n_pop[7:0]] == 8'hCC) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) $display("FAIL race_third_read got none want rd_en for cc"); else passed++;
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    wait_word(d, k, ok);
    checks++; if (!ok || d !== 32'h00CCBBAA) $display("FAIL race_data got %h want 00ccbbaa", d); else passed++;
    checks++; if (k !== 4'h7) $display("FAIL race_keep got %h want 7", k); else passed++;
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] d; logic [3:0] k; bit ok; bit hit; int base;
    do_reset();
    m_ready = 1'b1;
    base = n_pop;
    push(8'h21); push(8'h22); push(8'h23);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      if (n_pop - base == 3) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) $display("FAIL mid_reads got %0d want 3", n_pop - base); else passed++;
    rd_rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) $display("FAIL mid_reset_outputs got %b/%b want 0/0", m_valid, fifo_rd_en); else passed++;
    @(negedge rd_clk);
    rd_rst = 1'b0;
    repeat (3) @(negedge rd_clk);
    checks++; if (m_valid !== 1'b0) $display("FAIL mid_no_word got %b want 0", m_valid); else passed++;
    checks++; if (word_count !== 32'd0) $display("FAIL mid_count got %0d want 0", word_count); else passed++;
    force dut.word_count = 32'hFFFFFFFF;
    #1;
    release dut.word_count;
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    wait_word(d, k, ok);
    checks++; if (!ok || d !== 32'h34333231) $display("FAIL post_reset_lane0 got %h want 34333231", d); else passed++;
    checks++; if (k !== 4'hF) $display("FAIL post_reset_keep got %h want f", k); else passed++;
    repeat (2) @(negedge rd_clk);
    checks++; if (word_count !== 32'd0) $display("FAIL count_wrap got %h want 00000000", word_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_partial();
    test_flush_race();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
